instruction_fetch_unit: RTL and testbench

Fetch stage sitting between the program counter and decode, driving the address port of the instruction RAM and registering the 32-bit instruction it returns. It owns the PC. It presents one instruction per cycle to decode via a valid/ready handshake and accepts redirects (taken branches, jump-register) from later stages. It stops fetching on a halt instruction.

---
 rtl/cpu_fetch_pkg.sv | 23 ++
 rtl/fetch_predecode.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg
//   Shared definitions for the instruction fetch stage: default bus widths,
//   opcode field position, the opcodes fetch reacts to, and the fetch state
//   encoding.
package cpu_fetch_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    // Opcode occupies the top six bits of every instruction word.
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;

    localparam logic [5:0] OPC_JUMP = 6'b010101;
    localparam logic [5:0] OPC_HALT = 6'b111111;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALT   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_predecode.sv
// fetch_predecode
//   Combinational pre-decode of a fetched instruction word.
//   Ports:
//     instr       in  DATA_WIDTH  instruction word from the RAM
//     is_jump     out 1           opcode is JUMP
//     is_halt     out 1           opcode is HALT
//     jump_target out ADDR_WIDTH  absolute JUMP target (low address bits)
module fetch_predecode
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] instr,
    output logic                  is_jump,
    output logic                  is_halt,
    output logic [ADDR_WIDTH-1:0] jump_target
);

    logic [5:0] opcode;

    // Bits between the target field and the opcode carry no meaning here.
    logic unused_mid_bits;
    assign unused_mid_bits = ^instr[OPC_LSB-1:ADDR_WIDTH];

    assign opcode      = instr[OPC_MSB:OPC_LSB];
    assign is_jump     = (opcode == OPC_JUMP);
    assign is_halt     = (opcode == OPC_HALT);
    assign jump_target = instr[ADDR_WIDTH-1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage: owns the PC, addresses the instruction RAM, registers the
//   returned word and hands it to decode over a valid/ready handshake.
//   Accepts redirects from later stages and stops on HALT.
//   Optional feature: define FETCH_EARLY_JUMP_EN to follow JUMP targets at
//   fetch time (no bubble); otherwise JUMP advances PC by one like any word.
//   Ports:
//     clock, reset      rising-edge clock, synchronous active-high reset
//     iram_address out  RAM address (the PC)
//     iram_data    in   RAM read data, combinational from iram_address
//     instr_out    out  registered instruction to decode
//     instr_pc     out  address instr_out came from
//     instr_valid  out  instr_out holds an undelivered instruction
//     instr_ready  in   decode accepts instr_out this cycle
//     redirect_valid / redirect_target in  flush and refetch from target
//     halted       out  unit is in HALT
module instruction_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned          DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] iram_address,
    input  logic [DATA_WIDTH-1:0] iram_data,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  halted
);

`ifdef FETCH_EARLY_JUMP_EN
    localparam bit EARLY_JUMP = 1'b1;
`else
    localparam bit EARLY_JUMP = 1'b0;
`endif

    fetch_state_t          state;
    fetch_state_t          next_state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  fetch;
    logic                  is_jump;
    logic                  is_halt;
    logic [ADDR_WIDTH-1:0] jump_target;

    fetch_predecode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_predecode (
        .instr       (iram_data),
        .is_jump     (is_jump),
        .is_halt     (is_halt),
        .jump_target (jump_target)
    );

    assign iram_address = pc;
    assign halted       = (state == ST_HALT);

    // PC + 1 wraps naturally at 2^ADDR_WIDTH.
    assign next_pc = (EARLY_JUMP && is_jump) ? jump_target : pc + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_WARMUP;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fetch      = 1'b0;
        if (redirect_valid) begin
            next_state = ST_FETCH;
        end else begin
            unique case (state)
                ST_WARMUP: next_state = ST_FETCH;
                ST_FETCH: begin
                    fetch = !instr_valid || instr_ready;
                    if (fetch && is_halt) begin
                        next_state = ST_HALT;
                    end
                end
                ST_HALT: next_state = ST_HALT;
                default: next_state = ST_WARMUP;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= redirect_target;
            instr_valid <= 1'b0;
        end else if (fetch) begin
            instr_out   <= iram_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= next_pc;
        end else if (instr_ready) begin
            // Accept with nothing new to fetch (WARMUP/HALT) drains the slot.
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] iram_address;
    logic [DW-1:0] iram_data;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_target = '0;
    logic          halted;

    logic [DW-1:0] mem [0:DEPTH-1];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    assign iram_data = mem[iram_address];

    instruction_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (10'd0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .iram_address    (iram_address),
        .iram_data       (iram_data),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: mode 0 = warming up, 1 = fetching, 2 = halted.
    int          m_pc;
    logic [31:0] m_out;
    int          m_ipc;
    bit          m_valid;
    int          m_mode;
    bit          live = 1'b0;

    always @(posedge clock) begin
        logic [31:0] w;
        if (reset) begin
            m_pc = 0; m_out = 0; m_ipc = 0; m_valid = 0; m_mode = 0;
            live = 1'b1;
        end else if (live) begin
            if (redirect_valid) begin
                m_valid = 0;
                m_pc    = int'(redirect_target);
                m_mode  = 1;
            end else if (m_mode == 1 && (!m_valid || instr_ready)) begin
                w       = mem[m_pc];
                m_out   = w;
                m_ipc   = m_pc;
                m_valid = 1;
`ifdef FETCH_EARLY_JUMP_EN
                if (w[31:26] == 6'h15) m_pc = int'(w[9:0]);
                else m_pc = (m_pc + 1) % DEPTH;
`else
                m_pc = (m_pc + 1) % DEPTH;
`endif
                if (w[31:26] == 6'h3F) m_mode = 2;
            end else begin
                if (instr_ready) m_valid = 0;
                if (m_mode == 0) m_mode = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (live) begin
            check("addr",      32'(iram_address), 32'(m_pc));
            check("valid",     32'(instr_valid),  32'(m_valid));
            check("halted",    32'(halted),       32'(m_mode == 2));
            check("instr_out", instr_out,         m_out);
            check("instr_pc",  32'(instr_pc),     32'(m_ipc));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect(input int tgt);
        redirect_valid  = 1'b1;
        redirect_target = AW'(tgt);
        tick();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        int jexp;
        logic [31:0] r;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
        mem[1]  = 32'h5400000B;
        mem[25] = 32'hFC000000;

        // Reset, then WARMUP, then first delivery.
        tick(); tick();
        reset = 1'b0;
        check("rst_valid",  32'(instr_valid), 0);
        check("rst_out",    instr_out, 0);
        check("rst_ipc",    32'(instr_pc), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_addr",   32'(iram_address), 0);
        tick();
        check("warm_valid", 32'(instr_valid), 0);
        tick();
        check("e2_valid", 32'(instr_valid), 1);
        check("e2_ipc",   32'(instr_pc), 0);
        tick();
        check("e3_ipc", 32'(instr_pc), 1);
        check("e3_out", instr_out, 32'h5400000B);
        tick();
`ifdef FETCH_EARLY_JUMP_EN
        jexp = 11;
`else
        jexp = 2;
`endif
        check("after_jump_ipc", 32'(instr_pc), 32'(jexp));

        // Stall at instr_pc 5.
        redirect(5);
        check("rd5_valid", 32'(instr_valid), 0);
        check("rd5_addr",  32'(iram_address), 5);
        tick();
        check("pc5_ipc", 32'(instr_pc), 5);
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_ipc",  32'(instr_pc), 5);
            check("stall_out",  instr_out, 5);
            check("stall_addr", 32'(iram_address), 6);
        end
        instr_ready = 1'b1;
        tick();
        check("release_ipc", 32'(instr_pc), 6);

        // Redirect while stalled.
        instr_ready = 1'b0;
        tick();
        redirect(21);
        check("rd21_valid", 32'(instr_valid), 0);
        tick();
        check("rd21_ipc",   32'(instr_pc), 21);
        check("rd21_v",     32'(instr_valid), 1);
        instr_ready = 1'b1;

        // HALT at 25, then resume at 2.
        redirect(24);
        tick();
        check("pc24", 32'(instr_pc), 24);
        tick();
        check("halt_ipc", 32'(instr_pc), 25);
        check("halt_out", instr_out, 32'hFC000000);
        tick();
        check("halt_flag",  32'(halted), 1);
        check("halt_drain", 32'(instr_valid), 0);
        tick();
        check("halt_hold_addr", 32'(iram_address), 26);
        redirect(2);
        check("resume_halted", 32'(halted), 0);
        tick();
        check("resume_ipc", 32'(instr_pc), 2);

        // PC wrap.
        redirect(1023);
        tick();
        check("pc1023", 32'(instr_pc), 1023);
        tick();
        check("wrap_ipc", 32'(instr_pc), 0);

        // Randomized phase.
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom;
            case ($urandom_range(0, 15))
                0, 1:    r[31:26] = 6'h15;
                2:       r[31:26] = 6'h3F;
                default: ;
            endcase
            mem[i] = r;
        end
        for (int c = 0; c < 3000; c++) begin
            reset           = ($urandom_range(0, 99) == 0);
            redirect_valid  = ($urandom_range(0, 99) < 6);
            redirect_target = AW'($urandom);
            instr_ready     = ($urandom_range(0, 99) < 70);
            tick();
        end
        reset = 1'b0;
        redirect_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
